// File: rtl/vga_scroll_addr_gen.sv
// Raster-to-framebuffer address generator for a scaled, vertically scrolling window.
// One registered address stage; scroll position advances on frame_tick_i under player control.
module vga_scroll_addr_gen #(
    parameter int X0          = 160,
    parameter int Y0          = 120,
    parameter int WIN_W       = 320,
    parameter int WIN_H       = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int MEM_ROWS    = 240,
    parameter int ADDR_W      = 16,
    localparam int POS_W      = (MEM_ROWS > 1) ? $clog2(MEM_ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt_i,
    input  logic [9:0]        v_cnt_i,
    input  logic              frame_tick_i,
    input  logic [1:0]        mode_i,
    input  logic              play_toggle_i,
    input  logic              dir_i,
    input  logic [3:0]        step_i,
    input  logic              restart_i,
    output logic [ADDR_W-1:0] pixel_addr_o,
    output logic              in_window_o,
    output logic [POS_W-1:0]  position_o,
    output logic              playing_o
);

    localparam int MEM_W    = WIN_W >> SCALE_SHIFT;
    localparam int VIS_ROWS = WIN_H >> SCALE_SHIFT;
    localparam int PP_MAX   = MEM_ROWS - VIS_ROWS;
    localparam int SUM_W    = POS_W + 1;

    localparam logic [10:0]      X_LO   = 11'(X0);
    localparam logic [10:0]      X_HI   = 11'(X0 + WIN_W);
    localparam logic [10:0]      Y_LO   = 11'(Y0);
    localparam logic [10:0]      Y_HI   = 11'(Y0 + WIN_H);
    localparam logic [SUM_W-1:0] ROWS_S = SUM_W'(MEM_ROWS);
    localparam logic [SUM_W-1:0] PP_S   = SUM_W'(PP_MAX);

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'd0,
        MODE_LOOP     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    mode_e mode;
    assign mode = mode_e'(mode_i);

    logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
    logic              in_window_q, in_window_d;
    logic [POS_W-1:0]  position_q, position_d;
    logic              playing_q, playing_d;
    logic              bounce_q, bounce_d;   // 0: ping-pong heading forward

    logic              win_hit;
    logic [9:0]        h_off, v_off, col, row;
    logic [SUM_W-1:0]  row_sum, mem_row;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pixel_addr_d = '0;
        win_hit = ({1'b0, h_cnt_i} >= X_LO) && ({1'b0, h_cnt_i} < X_HI) &&
                  ({1'b0, v_cnt_i} >= Y_LO) && ({1'b0, v_cnt_i} < Y_HI);
        h_off   = h_cnt_i - X_LO[9:0];
        v_off   = v_cnt_i - Y_LO[9:0];
        col     = h_off >> SCALE_SHIFT;
        row     = v_off >> SCALE_SHIFT;
        // Both addends are below MEM_ROWS inside the window, so one subtraction wraps.
        row_sum = SUM_W'(row) + SUM_W'(position_q);
        mem_row = (row_sum >= ROWS_S) ? row_sum - ROWS_S : row_sum;
        in_window_d = win_hit;
        if (win_hit) begin
            pixel_addr_d = ADDR_W'(mem_row) * ADDR_W'(MEM_W) + ADDR_W'(col);
        end
    end

    logic [SUM_W-1:0] pos_s, step_s, fwd_sum;
    logic             heading_up;

    always_comb begin
        position_d = position_q;
        bounce_d   = bounce_q;
        playing_d  = playing_q ^ play_toggle_i;
        pos_s      = SUM_W'(position_q);
        step_s     = SUM_W'(step_i);
        fwd_sum    = pos_s + step_s;
        heading_up = ~(bounce_q ^ dir_i);

        if (restart_i) begin
            position_d = '0;
            bounce_d   = 1'b0;
        end else if (frame_tick_i && playing_q) begin
            unique case (mode)
                MODE_LOOP: begin
                    if (!dir_i) begin
                        position_d = POS_W'((fwd_sum >= ROWS_S) ? fwd_sum - ROWS_S : fwd_sum);
                    end else begin
                        position_d = POS_W'((pos_s >= step_s) ? pos_s - step_s
                                                              : pos_s + ROWS_S - step_s);
                    end
                end
                MODE_PINGPONG: begin
                    if (pos_s > PP_S) begin
                        // Arrived from loop mode beyond the bounce range: park at the top, head down.
                        position_d = POS_W'(PP_S);
                        bounce_d   = ~dir_i;
                    end else if (heading_up) begin
                        if (fwd_sum >= PP_S) begin
                            position_d = POS_W'(PP_S);
                            bounce_d   = ~bounce_q;
                        end else begin
                            position_d = POS_W'(fwd_sum);
                        end
                    end else begin
                        if (pos_s <= step_s) begin
                            position_d = '0;
                            bounce_d   = ~bounce_q;
                        end else begin
                            position_d = POS_W'(pos_s - step_s);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr_q <= '0;
            in_window_q  <= 1'b0;
            position_q   <= '0;
            playing_q    <= 1'b0;
            bounce_q     <= 1'b0;
        end else begin
            pixel_addr_q <= pixel_addr_d;
            in_window_q  <= in_window_d;
            position_q   <= position_d;
            playing_q    <= playing_d;
            bounce_q     <= bounce_d;
        end
    end

    assign pixel_addr_o = pixel_addr_q;
    assign in_window_o  = in_window_q;
    assign position_o   = position_q;
    assign playing_o    = playing_q;

endmodule
